i2s_tx: RTL and testbench
=========================

I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001: Parameter SAMPLE_BITS, default 16, sample width; SHALL be 16 in this release.
REQ-002: Parameter SLOT_BITS, default 32, bit-clock periods per channel slot.
REQ-003: mclk  input  1  master clock, 256x sample rate; sole clock.
REQ-004: rst  input  1  asynchronous, active-low reset.
REQ-005: s_left  input  16  signed (shortint) left sample.
REQ-006: s_right  input  16  signed (shortint) right sample.
REQ-007: s_valid  input  1  sample pair offered.
REQ-008: s_ready  output  1  pending buffer can accept a pair.
REQ-009: mute  input  1  transmit zeros while high.
REQ-010: pbclk  output  1  codec bit clock, mclk/4.
REQ-011: pblrc  output  1  playback LR clock, mclk/256; 0 = left, 1 = right.
REQ-012: pbdat  output  1  serial playback data, I2S format.
REQ-013: frame_tick  output  1  one-mclk pulse at each frame start.
REQ-014: underrun  output  1  one-mclk pulse when a frame starts with no pending pair.
REQ-015: underrun_cnt  output  16  saturating count of underruns.

Function
REQ-016: Frame counter fc, 8 bits, SHALL increment every mclk and wrap 255->0.
REQ-017: All outputs SHALL be registered and consistent with fc: on the edge where fc becomes n, pbclk=n[1] and pblrc=n[7].
REQ-018: Slot bit index k=n[6:2]; pbdat SHALL be 0 for k=0, active[15-(k-1)] for k=1..16, and 0 for k=17..31.
REQ-019: Channel selection: active = left register when n[7]=0, else right register.
REQ-020: Each bit SHALL be held for 4 mclk (fc 4k..4k+3), so pbdat changes only when pbclk falls, MSB first, with a one-bclk delay after the pblrc edge.
REQ-021: Pending buffer holds one pair; s_ready SHALL equal !pending_full.
REQ-022: A pair is accepted on an mclk edge with s_valid && s_ready; pending_full SHALL set on that edge.
REQ-023: On the edge where fc becomes 0, frame_tick SHALL pulse high for exactly one mclk.
REQ-024: On that same edge, if pending_full was set: the left/right active registers SHALL load the pending pair, and pending_full SHALL clear.
REQ-025: Otherwise, the active registers SHALL load 0, underrun SHALL pulse, and underrun_cnt SHALL increment, saturating at 0xFFFF.
REQ-026: The load SHALL use the pending contents from before the edge; no bypass. An accept cannot coincide with a load from a full buffer, because s_ready=0.
REQ-027: An accept on the load edge with the buffer empty SHALL fill pending for the next frame, and the underrun for the current frame still counts.
REQ-028: mute=1 at load SHALL load zeros while still consuming a full pending buffer; an underrun under mute SHALL still count.
REQ-029: Latency: an accepted pair SHALL first appear at the next frame start, and its MSB SHALL appear at fc=4 of that frame.
REQ-030: s_left/s_right SHALL be sampled only on the accept edge; later changes SHALL have no effect.

Reset
REQ-031: While rst=0, the block SHALL hold fc=0, pbclk=0, pblrc=0, pbdat=0, frame_tick=0, underrun=0, underrun_cnt=0, pending_full=0 and active registers=0.
REQ-032: While rst=0, s_ready SHALL be 1.
REQ-033: Reset assertion SHALL take effect immediately, mid-frame or mid-bit, and discard any pending pair.
REQ-034: Release SHALL be synchronous-safe, through a two-flop deassert synchronizer on mclk.
REQ-035: After release, the first frame_tick SHALL occur when fc first wraps to 0, 256 mclk later.

Verification
REQ-036: Reset, then push L=0xA5C3, R=0x7FFF before the first wrap -> next frame: left bits 1..16 = 1010010111000011, right = 0111111111111111, zeros elsewhere, underrun_cnt=0.
REQ-037: Reset with no pushes for 3 frames -> pbdat constant 0, three underrun pulses, underrun_cnt=3, pbclk period 4 mclk, pblrc period 256 mclk with 50% duty.
REQ-038: Hold s_valid high continuously with incrementing data -> exactly one accept per frame, each accepted one mclk after frame_tick; s_ready low otherwise; no underruns.
REQ-039: s_valid rises on the same edge fc becomes 0 with the buffer empty -> underrun pulses for that frame; the pair plays in the following frame.
REQ-040: mute=1 with a pending pair L=0x8000 -> zeros transmitted, pending consumed, s_ready=1, no underrun.
REQ-041: Assert rst at fc=137 -> all outputs 0 immediately, pending discarded; after release, first frame_tick 256 mclk later; force underrun_cnt to 0xFFFF and then underrun -> count stays 0xFFFF.

Source files
------------

// File: rtl/i2s_tx.sv
// I2S playback transmitter: one-pair pending buffer feeding a 256-mclk frame,
// with bclk/lrclk/data all registered off a single 8-bit frame counter.
module i2s_tx #(
  parameter int SAMPLE_BITS = 16,
  parameter int SLOT_BITS   = 32
) (
  input  logic                   mclk,
  input  logic                   rst,
  input  logic [SAMPLE_BITS-1:0] s_left,
  input  logic [SAMPLE_BITS-1:0] s_right,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic                   mute,
  output logic                   pbclk,
  output logic                   pblrc,
  output logic                   pbdat,
  output logic                   frame_tick,
  output logic                   underrun,
  output logic [15:0]            underrun_cnt
);

  // 4 mclk per bit, SLOT_BITS bits per channel, two channels
  localparam int FC_W = $clog2(SLOT_BITS) + 3;
  localparam int K_W  = FC_W - 3;

  logic [1:0]             rst_sync;
  logic                   rst_i;
  logic [FC_W-1:0]        fc;
  logic [FC_W-1:0]        fc_next;
  logic                   wrap;
  logic [K_W-1:0]         k_next;
  logic                   pending_full;
  logic                   accept;
  logic [SAMPLE_BITS-1:0] pend_l;
  logic [SAMPLE_BITS-1:0] pend_r;
  logic [SAMPLE_BITS-1:0] act_l;
  logic [SAMPLE_BITS-1:0] act_r;
  logic [SAMPLE_BITS-1:0] chan;
  logic [SAMPLE_BITS-1:0] chan_sh;
  logic                   data_bit;
  int                     k;

  // Assert asynchronously, release two mclk edges after rst rises
  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) rst_sync <= '0;
    else      rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_i = rst_sync[1];

  assign fc_next = fc + 1'b1;
  assign wrap    = (fc_next == '0);
  assign k_next  = fc_next[FC_W-2:2];
  assign s_ready = !pending_full;
  assign accept  = s_valid && s_ready;

  // Outputs are computed from the count being entered, so they line up with fc
  always_comb begin
    data_bit = 1'b0;
    chan     = fc_next[FC_W-1] ? act_r : act_l;
    chan_sh  = '0;
    k        = int'(k_next);
    if (k >= 1 && k <= SAMPLE_BITS) begin
      chan_sh  = chan << (k - 1);
      data_bit = chan_sh[SAMPLE_BITS-1];
    end
  end

  always_ff @(posedge mclk or negedge rst_i) begin
    if (!rst_i) begin
      fc         <= '0;
      pbclk      <= 1'b0;
      pblrc      <= 1'b0;
      pbdat      <= 1'b0;
      frame_tick <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      fc         <= fc_next;
      pbclk      <= fc_next[1];
      pblrc      <= fc_next[FC_W-1];
      pbdat      <= data_bit;
      frame_tick <= wrap;
      underrun   <= wrap && !pending_full;
    end
  end

  always_ff @(posedge mclk or negedge rst_i) begin
    if (!rst_i) begin
      underrun_cnt <= '0;
    end else if (wrap && !pending_full && underrun_cnt != 16'hFFFF) begin
      underrun_cnt <= underrun_cnt + 1'b1;
    end
  end

  // An accept never coincides with consuming a full buffer since s_ready is low then
  always_ff @(posedge mclk or negedge rst_i) begin
    if (!rst_i) begin
      pending_full <= 1'b0;
      pend_l       <= '0;
      pend_r       <= '0;
    end else if (accept) begin
      pending_full <= 1'b1;
      pend_l       <= s_left;
      pend_r       <= s_right;
    end else if (wrap) begin
      pending_full <= 1'b0;
    end
  end

  always_ff @(posedge mclk or negedge rst_i) begin
    if (!rst_i) begin
      act_l <= '0;
      act_r <= '0;
    end else if (wrap) begin
      if (pending_full && !mute) begin
        act_l <= pend_l;
        act_r <= pend_r;
      end else begin
        act_l <= '0;
        act_r <= '0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: expected frames queued at accept, checked bit by bit as they play.
module tb_i2s_tx;

  logic        mclk = 1'b0;
  logic        rst  = 1'b1;
  logic [15:0] s_left = '0;
  logic [15:0] s_right = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        mute = 1'b0;
  logic        pbclk, pblrc, pbdat, frame_tick, underrun;
  logic [15:0] underrun_cnt;

  i2s_tx #(.SAMPLE_BITS(16), .SLOT_BITS(32)) dut (
    .mclk(mclk), .rst(rst), .s_left(s_left), .s_right(s_right),
    .s_valid(s_valid), .s_ready(s_ready), .mute(mute),
    .pbclk(pbclk), .pblrc(pblrc), .pbdat(pbdat),
    .frame_tick(frame_tick), .underrun(underrun), .underrun_cnt(underrun_cnt)
  );

  always #5 mclk = ~mclk;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic        ur;
  } frame_t;

  frame_t      q[$];
  frame_t      cur;
  bit          cur_valid = 0;
  int          p = 0;
  int          err = 0;
  int          kk;
  logic [15:0] got_l, got_r, sh;
  logic [15:0] exp_cnt = '0;
  logic        exp_b;
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Frame monitor: a frame with nothing queued must be a zero frame with an underrun
  always @(negedge mclk) begin
    if (!rst) begin
      cur_valid = 0;
      q.delete();
      exp_cnt = '0;
    end else begin
      if (frame_tick) begin
        if (cur_valid) begin
          chk("frame_len", 32'(p), 32'd256);
          chk("left_word", 32'(got_l), 32'(cur.l));
          chk("right_word", 32'(got_r), 32'(cur.r));
          chk("frame_bits", 32'(err), 32'd0);
        end
        if (q.size() > 0) cur = q.pop_front();
        else cur = '{16'h0, 16'h0, 1'b1};
        cur_valid = 1;
        if (cur.ur && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        chk("underrun", 32'(underrun), 32'(cur.ur));
        chk("ur_cnt", 32'(underrun_cnt), 32'(exp_cnt));
        p = 0; err = 0; got_l = '0; got_r = '0;
      end
      if (cur_valid) begin
        kk = (p >> 2) & 31;
        exp_b = 1'b0;
        if (kk >= 1 && kk <= 16) begin
          sh = p[7] ? cur.r : cur.l;
          sh = sh << (kk - 1);
          exp_b = sh[15];
        end
        if (pbclk !== p[1] || pblrc !== p[7] || pbdat !== exp_b ||
            frame_tick !== (p == 0) || (p != 0 && underrun !== 1'b0))
          err++;
        if (p[1:0] == 2'd2 && kk >= 1 && kk <= 16) begin
          if (p[7]) got_r = {got_r[14:0], pbdat};
          else      got_l = {got_l[14:0], pbdat};
        end
        p++;
      end
    end
  end

  task automatic wait_tick();
    bit seen = 0;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(posedge mclk);
      #1;
      seen = frame_tick;
    end
    chk("tick_seen", 32'(seen), 32'd1);
  endtask

  // Offers a pair until accepted; expectation queued after the monitor handles that edge
  task automatic push(input logic [15:0] l, input logic [15:0] r,
                      input logic [15:0] el, input logic [15:0] er, input bit exp_en);
    bit done = 0;
    @(negedge mclk);
    s_left = l; s_right = r; s_valid = 1'b1;
    for (int i = 0; i < 600 && !done; i++) begin
      if (i > 0) @(negedge mclk);
      done = s_ready;
      @(posedge mclk);
    end
    #1;
    s_valid = 1'b0; s_left = 16'hDEAD; s_right = 16'hBEEF;
    chk("push_acc", 32'(done), 32'd1);
    @(negedge mclk);
    #1;
    if (done && exp_en) q.push_back('{el, er, 1'b0});
  endtask

  task automatic rst_checks();
    chk("rst_pbclk", 32'(pbclk), 32'd0);
    chk("rst_pblrc", 32'(pblrc), 32'd0);
    chk("rst_pbdat", 32'(pbdat), 32'd0);
    chk("rst_tick", 32'(frame_tick), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_ur_cnt", 32'(underrun_cnt), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
  endtask

  logic [15:0] d, acc_l, acc_r;
  int          accepts, n;
  bit          pend, seen;

  initial begin
    #3 rst = 1'b0;
    repeat (3) @(negedge mclk);
    rst_checks();

    // First frame after release plays the pair pushed before the first wrap
    @(negedge mclk) rst = 1'b1;
    repeat (10) @(posedge mclk);
    push(16'hA5C3, 16'h7FFF, 16'hA5C3, 16'h7FFF, 1'b1);
    wait_tick();

    // Idle frames: zeros and one underrun each
    repeat (3) wait_tick();

    // Continuous s_valid: accept only right after each frame_tick
    d = 16'h0100; s_left = d; s_right = ~d;
    accepts = 0; pend = 0;
    for (int i = 0; i < 1200 && accepts < 3; i++) begin
      @(negedge mclk);
      #1;
      if (pend) begin q.push_back('{acc_l, acc_r, 1'b0}); pend = 0; end
      s_valid = 1'b1;
      if (s_ready) begin
        chk("acc_phase", 32'(frame_tick), 32'd1);
        acc_l = s_left; acc_r = s_right;
        accepts++; pend = 1;
      end
      @(posedge mclk);
      #1;
      if (pend) begin d = d + 16'h0101; s_left = d; s_right = ~d; end
    end
    chk("acc_count", 32'(accepts), 32'd3);
    @(negedge mclk);
    #1;
    if (pend) q.push_back('{acc_l, acc_r, 1'b0});
    s_valid = 1'b0;
    repeat (5) wait_tick();

    // s_valid offered so that the accept lands on the wrap edge with buffer empty
    repeat (255) @(posedge mclk);
    push(16'h1357, 16'h9BDF, 16'h1357, 16'h9BDF, 1'b1);
    chk("wrap_acc_tick", 32'(frame_tick), 32'd1);
    chk("wrap_acc_ur", 32'(underrun), 32'd1);
    wait_tick();
    wait_tick();

    // Mute at load: pending consumed, zeros sent, no underrun
    push(16'h8000, 16'h1234, 16'h0000, 16'h0000, 1'b1);
    mute = 1'b1;
    wait_tick();
    chk("mute_ready", 32'(s_ready), 32'd1);
    chk("mute_no_ur", 32'(underrun), 32'd0);
    @(negedge mclk) mute = 1'b0;
    wait_tick();

    // Reset at fc=137 with a pending pair that must be discarded
    push(16'hFACE, 16'hCAFE, 16'h0, 16'h0, 1'b0);
    repeat (136) @(posedge mclk);
    #2 rst = 1'b0;
    #1 rst_checks();
    repeat (3) @(negedge mclk);
    rst_checks();
    @(negedge mclk) rst = 1'b1;
    // two synchronizer edges, then 256 counts to the wrap
    n = 0; seen = 0;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(posedge mclk);
      #1;
      n++;
      seen = frame_tick;
    end
    chk("rel_to_tick", 32'(n), 32'd258);

    // Saturation of the underrun counter
    @(negedge mclk);
    force dut.underrun_cnt = 16'hFFFF;
    exp_cnt = 16'hFFFF;
    @(negedge mclk);
    release dut.underrun_cnt;
    wait_tick();
    wait_tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
